// File: rtl/id_operand_stage_if.sv
// IF-to-ID bus plus the decoded ID-stage outputs (instruction, operands, interlock).
// The stage is the slave; the upstream driver / consumer side is the master.
interface id_operand_stage_if #(
   parameter int PCW = 32,
   parameter int DW  = 32
);
   logic           in_valid;
   logic [PCW-1:0] in_pc;
   logic [31:0]    inst_rdata;
   logic           out_valid;
   logic [PCW-1:0] out_pc;
   logic [31:0]    out_inst;
   logic [DW-1:0]  opnd1;
   logic [DW-1:0]  opnd2;
   logic           stallreq;

   modport master (
      output in_valid, in_pc, inst_rdata,
      input  out_valid, out_pc, out_inst, opnd1, opnd2, stallreq
   );

   modport slave (
      input  in_valid, in_pc, inst_rdata,
      output out_valid, out_pc, out_inst, opnd1, opnd2, stallreq
   );
endinterface

// File: rtl/id_operand_stage.sv
// ID stage: IF/ID pipeline register, SRAM hold buffer, forwarded operand
// resolution and load-use interlock with a saturating stall counter.
module id_opnd_resolve #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int NSRC = 3
) (
   input  logic [AW-1:0]      addr,
   input  logic [DW-1:0]      rf_rdata,
   input  logic [NSRC-1:0]    fwd_we,
   input  logic [NSRC-1:0]    fwd_is_load,
   input  logic [NSRC*AW-1:0] fwd_waddr,
   input  logic [NSRC*DW-1:0] fwd_wdata,
   output logic [DW-1:0]      value,
   output logic               load_hit
);
   // Walk oldest to youngest so the lowest matching index wins last.
   always_comb begin
      value    = rf_rdata;
      load_hit = 1'b0;
      for (int i = NSRC-1; i >= 0; i--) begin
         if (fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr)) begin
            value    = fwd_wdata[i*DW +: DW];
            load_hit = fwd_is_load[i];
         end
      end
      if (addr == '0) begin
         value    = '0;
         load_hit = 1'b0;
      end
   end
endmodule

module id_operand_stage #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int NSRC = 3,
   parameter int PCW  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_if,
   input  logic               stall_id,
   id_operand_stage_if.slave  bus,
   output logic [AW-1:0]      rf_raddr1,
   output logic [AW-1:0]      rf_raddr2,
   input  logic [DW-1:0]      rf_rdata1,
   input  logic [DW-1:0]      rf_rdata2,
   input  logic [NSRC-1:0]    fwd_we,
   input  logic [NSRC-1:0]    fwd_is_load,
   input  logic [NSRC*AW-1:0] fwd_waddr,
   input  logic [NSRC*DW-1:0] fwd_wdata,
   output logic [7:0]         stall_cnt
);
   logic           valid_q;
   logic [PCW-1:0] pc_q;
   logic           hold_v;
   logic [31:0]    hold_inst;
   logic [31:0]    inst;
   logic           bubble;

   logic [1:0][AW-1:0] raddr;
   logic [1:0][DW-1:0] rdata;
   logic [1:0][DW-1:0] opnd;
   logic [1:0]         load_hit;

   assign bubble = stall_if && !stall_id;

   always_ff @(posedge clk) begin
      if (rst || bubble) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
      end else if (!stall_if) begin
         valid_q <= bus.in_valid;
         pc_q    <= bus.in_pc;
      end
   end

   // The SRAM output only lasts one cycle after capture; freeze it for the stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v    <= 1'b0;
         hold_inst <= '0;
      end else if (bubble || !stall_if) begin
         hold_v    <= 1'b0;
      end else if (valid_q && !hold_v) begin
         hold_v    <= 1'b1;
         hold_inst <= bus.inst_rdata;
      end
   end

   assign inst = hold_v ? hold_inst : (valid_q ? bus.inst_rdata : 32'h0);

   assign raddr[0]  = AW'(inst[25:21]);
   assign raddr[1]  = AW'(inst[20:16]);
   assign rdata[0]  = rf_rdata1;
   assign rdata[1]  = rf_rdata2;
   assign rf_raddr1 = raddr[0];
   assign rf_raddr2 = raddr[1];

   for (genvar g = 0; g < 2; g++) begin : g_res
      id_opnd_resolve #(.DW(DW), .AW(AW), .NSRC(NSRC)) u_res (
         .addr        (raddr[g]),
         .rf_rdata    (rdata[g]),
         .fwd_we      (fwd_we),
         .fwd_is_load (fwd_is_load),
         .fwd_waddr   (fwd_waddr),
         .fwd_wdata   (fwd_wdata),
         .value       (opnd[g]),
         .load_hit    (load_hit[g])
      );
   end

   assign bus.out_valid = valid_q;
   assign bus.out_pc    = pc_q;
   assign bus.out_inst  = inst;
   assign bus.opnd1     = opnd[0];
   assign bus.opnd2     = opnd[1];
   assign bus.stallreq  = valid_q && (|load_hit);

   always_ff @(posedge clk) begin
      if (rst || !bus.stallreq)
         stall_cnt <= '0;
      else if (stall_cnt != 8'hFF)
         stall_cnt <= stall_cnt + 8'd1;
   end
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: forwarding priority, r0, load-use
// interlock and counter, hold buffer, bubble and reset-during-stall.
module tb_id_operand_stage;
   localparam int DW = 32, AW = 5, NSRC = 3, PCW = 32;

   logic clk = 1'b0;
   logic rst, stall_if, stall_id;
   logic [AW-1:0] rf_raddr1, rf_raddr2;
   logic [DW-1:0] rf_rdata1, rf_rdata2;
   logic [NSRC-1:0] fwd_we, fwd_is_load;
   logic [NSRC-1:0][AW-1:0] fwd_waddr;
   logic [NSRC-1:0][DW-1:0] fwd_wdata;
   logic [7:0] stall_cnt;
   int n_chk = 0, n_fail = 0;

   id_operand_stage_if #(.PCW(PCW), .DW(DW)) bus ();

   id_operand_stage #(.DW(DW), .AW(AW), .NSRC(NSRC), .PCW(PCW)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall_if    (stall_if),
      .stall_id    (stall_id),
      .bus         (bus.slave),
      .rf_raddr1   (rf_raddr1),
      .rf_raddr2   (rf_raddr2),
      .rf_rdata1   (rf_rdata1),
      .rf_rdata2   (rf_rdata2),
      .fwd_we      (fwd_we),
      .fwd_is_load (fwd_is_load),
      .fwd_waddr   (fwd_waddr),
      .fwd_wdata   (fwd_wdata),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input int i, input logic we, input logic ld,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      fwd_we[i]      = we;
      fwd_is_load[i] = ld;
      fwd_waddr[i]   = a;
      fwd_wdata[i]   = d;
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
      return {6'h0, rs, rt, 16'h0};
   endfunction

   initial begin
      rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0;
      bus.in_valid = 1'b1; bus.in_pc = 32'h44; bus.inst_rdata = 32'hFFFF_FFFF;
      rf_rdata1 = 32'h1111_1111; rf_rdata2 = 32'h2222_2222;
      fwd_we = '0; fwd_is_load = '0; fwd_waddr = '0; fwd_wdata = '0;

      // Reset state
      tick(); tick();
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_pc", bus.out_pc, 0);
      chk("rst_inst", bus.out_inst, 0);
      chk("rst_stallreq", bus.stallreq, 0);
      chk("rst_cnt", stall_cnt, 0);

      // Capture and forwarding priority
      rst = 1'b0; bus.in_pc = 32'h40; bus.inst_rdata = mk(5'd8, 5'd0);
      tick();
      chk("cap_valid", bus.out_valid, 1);
      chk("cap_pc", bus.out_pc, 32'h40);
      chk("cap_inst", bus.out_inst, mk(5'd8, 5'd0));
      chk("raddr1", rf_raddr1, 8);
      chk("rf_path", bus.opnd1, 32'h1111_1111);
      chk("rt_zero", bus.opnd2, 0);
      set_fwd(0, 1, 0, 5'd8, 32'hAAAA_0000);
      set_fwd(1, 1, 0, 5'd8, 32'hBBBB_0000);
      chk("fwd_src0", bus.opnd1, 32'hAAAA_0000);
      set_fwd(0, 0, 0, 5'd8, 32'hAAAA_0000);
      chk("fwd_src1", bus.opnd1, 32'hBBBB_0000);
      set_fwd(1, 1, 0, 5'd7, 32'hBBBB_0000);
      set_fwd(2, 1, 0, 5'd8, 32'hCCCC_0000);
      chk("fwd_src2", bus.opnd1, 32'hCCCC_0000);
      fwd_we = '0;

      // Zero register never forwarded, never interlocks
      bus.inst_rdata = mk(5'd0, 5'd0);
      set_fwd(0, 1, 1, 5'd0, 32'hDEAD_BEEF);
      chk("r0_op1", bus.opnd1, 0);
      chk("r0_op2", bus.opnd2, 0);
      chk("r0_stall", bus.stallreq, 0);

      // Load-use interlock and counter
      bus.inst_rdata = mk(5'd3, 5'd9);
      set_fwd(0, 1, 1, 5'd9, 32'h9999_9999);
      chk("lu_stall", bus.stallreq, 1);
      tick(); chk("lu_cnt1", stall_cnt, 1);
      tick(); chk("lu_cnt2", stall_cnt, 2);
      tick(); chk("lu_cnt3", stall_cnt, 3);
      set_fwd(0, 1, 0, 5'd9, 32'h9999_9999);
      chk("lu_drop", bus.stallreq, 0);
      chk("lu_op2", bus.opnd2, 32'h9999_9999);
      tick(); chk("lu_cnt0", stall_cnt, 0);
      // Younger non-load shadows an older load
      set_fwd(1, 1, 1, 5'd9, 32'h7777_7777);
      chk("shadow_stall", bus.stallreq, 0);
      chk("shadow_op2", bus.opnd2, 32'h9999_9999);
      fwd_we = '0; fwd_is_load = '0;

      // Hold buffer across a full stall
      bus.in_pc = 32'h100; bus.inst_rdata = 32'h3408_0001;
      tick();
      chk("hb_pc", bus.out_pc, 32'h100);
      chk("hb_inst", bus.out_inst, 32'h3408_0001);
      stall_if = 1'b1; stall_id = 1'b1; bus.in_pc = 32'h200;
      tick();
      bus.inst_rdata = 32'h0;
      set_fwd(0, 1, 1, 5'd8, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("hb_hold_inst", bus.out_inst, 32'h3408_0001);
         chk("hb_hold_pc", bus.out_pc, 32'h100);
         tick();
      end
      chk("hb_stall", bus.stallreq, 1);
      chk("hb_cnt", stall_cnt, 4);

      // Reset mid-stall
      bus.inst_rdata = 32'h55;
      rst = 1'b1;
      tick();
      chk("rs_valid", bus.out_valid, 0);
      chk("rs_inst", bus.out_inst, 0);
      chk("rs_cnt", stall_cnt, 0);
      chk("rs_stall", bus.stallreq, 0);
      rst = 1'b0;
      tick(); tick();
      chk("rs_valid_stalled", bus.out_valid, 0);
      chk("rs_inst_stalled", bus.out_inst, 0);
      stall_if = 1'b0; stall_id = 1'b0; bus.in_pc = 32'h300;
      tick();
      chk("rs_recap_valid", bus.out_valid, 1);
      chk("rs_recap_pc", bus.out_pc, 32'h300);
      chk("rs_recap_inst", bus.out_inst, 32'h55);

      // Bubble overrides a pending load match
      bus.inst_rdata = mk(5'd0, 5'd9);
      set_fwd(0, 1, 1, 5'd9, 32'h0);
      chk("bb_pre_stall", bus.stallreq, 1);
      stall_if = 1'b1; stall_id = 1'b0;
      tick();
      chk("bb_valid", bus.out_valid, 0);
      chk("bb_pc", bus.out_pc, 0);
      chk("bb_inst", bus.out_inst, 0);
      chk("bb_stall", bus.stallreq, 0);
      tick();
      chk("bb_cnt", stall_cnt, 0);

      // Counter saturation
      stall_if = 1'b0;
      tick();
      for (int i = 0; i < 256; i++) tick();
      chk("sat_255", stall_cnt, 255);
      tick();
      chk("sat_hold", stall_cnt, 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
